mode_router: RTL
================

MODE_ROUTER -- requirements
Module: mode_router

Interface
REQ-001 Parameter NUM_MODES, default 4, number of display/app modes; legal 2..8.
REQ-002 Parameter BTN_W, default 4, function buttons routed per mode; legal 1..8.
REQ-003 Parameter DATA_W, default 36, width of each mode's display word.
REQ-004 Parameter DEFAULT_MODE, default 0, mode entered at reset; legal 0..NUM_MODES-1.
REQ-005 Derived constant MODE_W = max(1, clog2(NUM_MODES)).
REQ-006 clk_i  in  1  system clock; the block's only clock.
REQ-007 reset_n  in  1  reset, asynchronous, active-low.
REQ-008 mode_next_i  in  1  debounced level, advance to next mode.
REQ-009 mode_prev_i  in  1  debounced level, step back to previous mode.
REQ-010 btn_i  in  BTN_W  debounced function-button levels.
REQ-011 mode_en_i  in  NUM_MODES  per-mode enable; disabled modes are skipped.
REQ-012 mode_data_i  in  NUM_MODES*DATA_W  display words; mode k occupies bits [k*DATA_W +: DATA_W].
REQ-013 mode_o  out  MODE_W  current mode, registered.
REQ-014 btn_o  out  NUM_MODES*BTN_W  one-cycle press pulses; mode k's buttons occupy bits [k*BTN_W +: BTN_W].
REQ-015 data_o  out  DATA_W  registered display word of the current mode.
REQ-016 mode_change_o  out  1  one-cycle pulse on every mode change.

Function
REQ-017 Rising edges of mode_next_i, mode_prev_i and each btn_i bit are detected against a one-cycle-delayed copy; only edges act.
REQ-018 mode_next edge: mode_o moves to the first enabled mode searching upward from mode_o+1, wrapping NUM_MODES-1 -> 0.
REQ-019 mode_prev edge: same search downward from mode_o-1, wrapping 0 -> NUM_MODES-1.
REQ-020 If no other enabled mode exists, mode_o holds and mode_change_o stays 0.
REQ-021 Simultaneous next and prev edges are ignored: no mode change, no pulse.
REQ-022 If mode_en_i[mode_o] is 0 in state RUN and at least one mode is enabled, a forced upward switch occurs the next cycle, exactly as a next edge would cause.
REQ-023 If mode_en_i is all zeros, mode_o holds and btn_o stays all zeros.
REQ-024 A mode change updates mode_o and pulses mode_change_o in the same cycle (1 cycle after the sampled edge).
REQ-025 In RUN, a btn_i[j] rising edge at cycle N gives btn_o[mode_o*BTN_W+j]=1 for exactly cycle N+1; all other btn_o bits stay 0.
REQ-026 A mode edge and a function-button edge in the same cycle: the mode change wins and the function edge is discarded.
REQ-027 FSM states RUN and LOCK. RUN -> LOCK on any mode change. LOCK -> RUN after the first cycle in which btn_i, mode_next_i and mode_prev_i are all 0. btn_o is all zeros in LOCK.
REQ-028 Mode edges are ignored while in LOCK.
REQ-029 data_o equals the mode_data_i slice selected by mode_o, registered, with 1-cycle latency; it follows the new mode one cycle after mode_o changes.

Reset
REQ-030 While reset_n=0: mode_o=DEFAULT_MODE, state=LOCK, btn_o=0, data_o=0, mode_change_o=0.
REQ-031 While reset_n=0, all edge-detector history registers are 1, so no edge fires from buttons held through reset release.
REQ-032 Reset asserted mid-pulse or mid-LOCK clears outputs immediately (asynchronously); no pending event survives reset.

Structure
REQ-033 Shared package mode_router_pkg holds the state enum (RUN, LOCK) and the pure functions next_enabled and prev_enabled (mask, current, NUM_MODES).
REQ-034 One sub-module, btn_edge: a parametrised-width rising-edge detector whose history registers reset to 1; it is instantiated for the mode and function buttons.
REQ-035 No combinational path exists from any input to any output.

Verification (NUM_MODES=4, BTN_W=4, DATA_W=36, DEFAULT_MODE=0)
REQ-036 Release reset with btn_i=4'b0001 held, then release it -> no btn_o pulse; state reaches RUN; then a press of bit0 -> btn_o[0]=1 for one cycle.
REQ-037 mode_en_i=4'b1011, mode_o=1, next edge -> mode_o=3, mode_change_o pulse; next edge again -> mode_o=0.
REQ-038 mode_o=0, prev edge -> mode_o=3; mode_data_i slice 3 = 36'h123456789 -> data_o = 36'h123456789 one cycle after mode_o changes.
REQ-039 Next and prev edges in the same cycle -> mode_o unchanged, mode_change_o=0; next edge plus btn edge in the same cycle -> mode change, btn_o all zeros, LOCK held until all inputs are 0.
REQ-040 mode_o=2, mode_en_i drops to 4'b0001 -> mode_o=0 the next cycle; mode_en_i=0 -> mode_o holds and btn_o stays 0.
REQ-041 Assert reset_n=0 during a btn_o pulse -> btn_o=0 and mode_o=0 immediately, with no clock edge required.

Source files
------------

// File: rtl/mode_router_pkg.sv
// Shared types and mode-search helpers for the mode router.
package mode_router_pkg;

    // RUN accepts mode and function edges; LOCK waits for every input to be released.
    typedef enum logic {
        RUN  = 1'b0,
        LOCK = 1'b1
    } state_e;

    // Widest mode count the search helpers handle.
    localparam int MAX_MODES = 8;

    // First enabled mode above cur, wrapping at num_modes. Returns cur when
    // no other mode is enabled, so callers can detect "nowhere to go".
    function automatic logic [2:0] next_enabled(input logic [7:0] mask,
                                                input logic [2:0] cur,
                                                input int         num_modes);
        logic [2:0] res;
        logic       found;
        int         idx;
        res   = cur;
        found = 1'b0;
        for (int i = 1; i < MAX_MODES; i++) begin
            if (i < num_modes && !found) begin
                idx = (int'(cur) + i) % num_modes;
                if (mask[idx[2:0]]) begin
                    res   = idx[2:0];
                    found = 1'b1;
                end
            end
        end
        return res;
    endfunction

    // First enabled mode below cur, wrapping from 0 to num_modes-1.
    function automatic logic [2:0] prev_enabled(input logic [7:0] mask,
                                                input logic [2:0] cur,
                                                input int         num_modes);
        logic [2:0] res;
        logic       found;
        int         idx;
        res   = cur;
        found = 1'b0;
        for (int i = 1; i < MAX_MODES; i++) begin
            if (i < num_modes && !found) begin
                idx = (int'(cur) - i + num_modes) % num_modes;
                if (mask[idx[2:0]]) begin
                    res   = idx[2:0];
                    found = 1'b1;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mode_router_btn_edge.sv
// Rising-edge detector for debounced levels. History resets to all ones so a
// level held high through reset release never looks like a fresh press.
module btn_edge #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         reset_n,
    input  logic [W-1:0] lvl_i,
    output logic [W-1:0] rise_o
);

    logic [W-1:0] hist_q;
    logic [W-1:0] hist_d;

    // Next history is simply the present level.
    always_comb begin
        hist_d = lvl_i;
    end

    // One-cycle-delayed copy of the levels.
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            hist_q <= '1;
        end else begin
            hist_q <= hist_d;
        end
    end

    for (genvar gi = 0; gi < W; gi++) begin : g_rise
        assign rise_o[gi] = lvl_i[gi] & ~hist_q[gi];
    end

endmodule

// File: rtl/mode_router.sv
// Mode router: steps through enabled modes on next/prev presses, routes the
// function buttons to the current mode as one-cycle pulses and presents the
// current mode's display word. All outputs come straight from flops.
module mode_router
    import mode_router_pkg::*;
#(
    parameter  int NUM_MODES    = 4,
    parameter  int BTN_W        = 4,
    parameter  int DATA_W       = 36,
    parameter  int DEFAULT_MODE = 0,
    localparam int MODE_W       = (NUM_MODES > 2) ? $clog2(NUM_MODES) : 1
) (
    input  logic                        clk_i,
    input  logic                        reset_n,
    input  logic                        mode_next_i,
    input  logic                        mode_prev_i,
    input  logic [BTN_W-1:0]            btn_i,
    input  logic [NUM_MODES-1:0]        mode_en_i,
    input  logic [NUM_MODES*DATA_W-1:0] mode_data_i,
    output logic [MODE_W-1:0]           mode_o,
    output logic [NUM_MODES*BTN_W-1:0]  btn_o,
    output logic [DATA_W-1:0]           data_o,
    output logic                        mode_change_o
);

    logic [1:0]       mode_rise;
    logic [BTN_W-1:0] fn_rise;

    btn_edge #(.W(2)) u_mode_edge (
        .clk_i   (clk_i),
        .reset_n (reset_n),
        .lvl_i   ({mode_prev_i, mode_next_i}),
        .rise_o  (mode_rise)
    );

    btn_edge #(.W(BTN_W)) u_fn_edge (
        .clk_i   (clk_i),
        .reset_n (reset_n),
        .lvl_i   (btn_i),
        .rise_o  (fn_rise)
    );

    state_e                       state_q, state_d;
    logic [MODE_W-1:0]            mode_q, mode_d;
    logic [NUM_MODES*BTN_W-1:0]   btn_q, btn_d;
    logic [DATA_W-1:0]            data_q, data_d;
    logic                         chg_q, chg_d;

    logic       next_rise;
    logic       prev_rise;
    logic       any_en;
    logic       cur_en;
    logic [7:0] mask8;
    logic [2:0] cur3;
    logic [2:0] up_tgt;
    logic [2:0] dn_tgt;

    // Candidate targets for an upward and a downward step from the current mode.
    always_comb begin
        next_rise = mode_rise[0];
        prev_rise = mode_rise[1];
        any_en    = |mode_en_i;
        cur_en    = mode_en_i[mode_q];
        mask8     = 8'(mode_en_i);
        cur3      = 3'(mode_q);
        up_tgt    = next_enabled(mask8, cur3, NUM_MODES);
        dn_tgt    = prev_enabled(mask8, cur3, NUM_MODES);
    end

    // Next-state and output decode; a mode change always beats a function press.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        btn_d   = '0;
        chg_d   = 1'b0;
        data_d  = mode_data_i[mode_q*DATA_W +: DATA_W];
        case (state_q)
            RUN: begin
                if (any_en && !cur_en) begin
                    // Current mode was disabled underneath us: move up as a next press would.
                    mode_d  = MODE_W'(up_tgt);
                    chg_d   = 1'b1;
                    state_d = LOCK;
                end else if (next_rise && !prev_rise && up_tgt != cur3) begin
                    mode_d  = MODE_W'(up_tgt);
                    chg_d   = 1'b1;
                    state_d = LOCK;
                end else if (prev_rise && !next_rise && dn_tgt != cur3) begin
                    mode_d  = MODE_W'(dn_tgt);
                    chg_d   = 1'b1;
                    state_d = LOCK;
                end else if (any_en) begin
                    btn_d[mode_q*BTN_W +: BTN_W] = fn_rise;
                end
            end
            LOCK: begin
                // Stay deaf until the user has let go of everything.
                if (btn_i == '0 && !mode_next_i && !mode_prev_i) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = LOCK;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= LOCK;
            mode_q  <= MODE_W'(DEFAULT_MODE);
            btn_q   <= '0;
            data_q  <= '0;
            chg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            btn_q   <= btn_d;
            data_q  <= data_d;
            chg_q   <= chg_d;
        end
    end

    assign mode_o        = mode_q;
    assign btn_o         = btn_q;
    assign data_o        = data_q;
    assign mode_change_o = chg_q;

endmodule
